seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 155 +++++++++++++++
 tb/tb_seq_divider.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle, WIDTH-bit operands.
// Define SIGNED_DIV_EN to add the is_signed port for two's-complement division.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SIGNED_DIV_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] q_out_q, q_out_d;
  logic [WIDTH-1:0] r_out_q, r_out_d;
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;
  logic dz_q, dz_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic sgn, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0] shifted;
  logic [WIDTH-1:0] diff;
  logic borrow;

`ifdef SIGNED_DIV_EN
  assign sgn = is_signed;
`else
  assign sgn = 1'b0;
`endif

  // Divide magnitudes; signs are reapplied in the DONE cycle.
  assign sa    = sgn & a[WIDTH-1];
  assign sb    = sgn & b[WIDTH-1];
  assign mag_a = sa ? -a : a;
  assign mag_b = sb ? -b : b;

  // WIDTH+1-bit trial subtract; low bits suffice when there is no borrow.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign borrow  = shifted < {1'b0, div_q};
  assign diff    = shifted[WIDTH-1:0] - div_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    busy_d  = (state_q == RUN);
    done_d  = (state_q == DONE);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = '0;
          div_d = mag_b;
          if (b == '0) begin
            dz_d    = 1'b1;
            quo_d   = '1;
            rem_d   = a;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = DONE;
          end else begin
            dz_d    = 1'b0;
            quo_d   = mag_a;
            rem_d   = '0;
            qneg_d  = sa ^ sb;
            rneg_d  = sa;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = borrow ? shifted[WIDTH-1:0] : diff;
        quo_d = {quo_q[WIDTH-2:0], ~borrow};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        q_out_d = qneg_q ? -quo_q : quo_q;
        r_out_d = rneg_q ? -rem_q : rem_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      q_out_q <= '0;
      r_out_q <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = q_out_q;
  assign remainder   = r_out_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: latency, results, reset, ignored starts.
// Signed cases run only when SIGNED_DIV_EN is defined.
module tb_seq_divider;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [W-1:0] a, b;
  logic is_signed;
  logic busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int checks = 0;
  int failures = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .a(a),
    .b(b),
`ifdef SIGNED_DIV_EN
    .is_signed(is_signed),
`endif
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain arithmetic on the operands.
  function automatic void model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                input logic sg, output logic [W-1:0] eq,
                                output logic [W-1:0] er, output logic edz);
    logic [W-1:0] minv;
    minv = {1'b1, {(W-1){1'b0}}};
    edz = (bb == 0);
    if (bb == 0) begin
      eq = '1;
      er = aa;
    end else if (!sg) begin
      eq = aa / bb;
      er = aa % bb;
    end else if (aa == minv && bb == '1) begin
      eq = minv;
      er = '0;
    end else begin
      eq = $signed(aa) / $signed(bb);
      er = $signed(aa) % $signed(bb);
    end
  endfunction

  // Starts a division, optionally pulses a second start, observes W+6 cycles.
  task automatic run_div(input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic sg, input int pulse_at,
                         input logic [W-1:0] pa, input logic [W-1:0] pb,
                         output int done_at, output int busy_n, output int done_n,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz);
    a = aa;
    b = bb;
    is_signed = sg;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    is_signed = ~sg;
    done_at = -1;
    busy_n = 0;
    done_n = 0;
    q = 'x;
    r = 'x;
    dz = 1'bx;
    for (int k = 1; k <= W + 6; k++) begin
      if (k == pulse_at) begin
        a = pa;
        b = pb;
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) begin
          done_at = k;
          q = quotient;
          r = remainder;
          dz = div_by_zero;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    a = 32'd10;
    b = 32'd3;
    is_signed = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b done=%b dz=%b q=%h r=%h required all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_start_ignored busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int da, bn, dn;
    logic [W-1:0] q, r;
    logic dz;
    run_div(32'd100, 32'd7, 1'b0, 0, '0, '0, da, bn, dn, q, r, dz);
    checks++;
    if (q !== 32'd14) begin failures++; $display("FAIL basic_q got %0d required 14", q); end
    checks++;
    if (r !== 32'd2) begin failures++; $display("FAIL basic_r got %0d required 2", r); end
    checks++;
    if (da !== W + 1) begin failures++; $display("FAIL basic_latency got %0d required %0d", da, W + 1); end
    checks++;
    if (bn !== W) begin failures++; $display("FAIL basic_busy_cycles got %0d required %0d", bn, W); end
    checks++;
    if (dn !== 1) begin failures++; $display("FAIL basic_done_count got %0d required 1", dn); end
    checks++;
    if (dz !== 1'b0) begin failures++; $display("FAIL basic_dz got %b required 0", dz); end
  endtask

  task automatic test_div_zero();
    int da, bn, dn;
    logic [W-1:0] q, r;
    logic dz;
    run_div(32'd5, 32'd0, 1'b0, 0, '0, '0, da, bn, dn, q, r, dz);
    checks++;
    if (q !== 32'hFFFF_FFFF || r !== 32'd5 || dz !== 1'b1) begin
      failures++;
      $display("FAIL dz_result q=%h r=%h dz=%b required ffffffff 5 1", q, r, dz);
    end
    checks++;
    if (da !== 1) begin failures++; $display("FAIL dz_latency got %0d required 1", da); end
    checks++;
    if (bn !== 0) begin failures++; $display("FAIL dz_busy got %0d required 0", bn); end
  endtask

  task automatic test_hold();
    for (int k = 0; k < 6; k++) begin
      a = $urandom;
      b = $urandom;
      @(posedge clk);
      #1;
    end
    checks++;
    if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd5 || div_by_zero !== 1'b1) begin
      failures++;
      $display("FAIL hold q=%h r=%h dz=%b required ffffffff 5 1", quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_edges();
    int da, bn, dn;
    logic [W-1:0] q, r;
    logic dz;
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0, '0, '0, da, bn, dn, q, r, dz);
    checks++;
    if (q !== 32'hFFFF_FFFF || r !== 32'd0) begin
      failures++;
      $display("FAIL edge_max_by_1 q=%h r=%h required ffffffff 0", q, r);
    end
    run_div(32'd3, 32'h8000_0000, 1'b0, 0, '0, '0, da, bn, dn, q, r, dz);
    checks++;
    if (q !== 32'd0 || r !== 32'd3) begin
      failures++;
      $display("FAIL edge_3_by_msb q=%h r=%h required 0 3", q, r);
    end
  endtask

  task automatic test_random(input logic sg, input int n);
    int da, bn, dn;
    logic [W-1:0] q, r, eq, er, aa, bb;
    logic dz, edz;
    for (int i = 0; i < n; i++) begin
      aa = $urandom;
      bb = $urandom >> $urandom_range(0, 31);
      if (i % 7 == 3) bb = '0;
      if (sg && i % 5 == 1) bb = -bb;
      model(aa, bb, sg, eq, er, edz);
      run_div(aa, bb, sg, 0, '0, '0, da, bn, dn, q, r, dz);
      checks++;
      if (q !== eq || r !== er || dz !== edz) begin
        failures++;
        $display("FAIL rand_%0d a=%h b=%h s=%b got q=%h r=%h dz=%b required q=%h r=%h dz=%b",
                 i, aa, bb, sg, q, r, dz, eq, er, edz);
      end
      checks++;
      if (da !== (edz ? 1 : W + 1) || dn !== 1) begin
        failures++;
        $display("FAIL rand_lat_%0d done_at=%0d done_n=%0d required %0d 1",
                 i, da, dn, edz ? 1 : W + 1);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int da, bn, dn;
    logic [W-1:0] q, r;
    logic dz;
    run_div(32'd100, 32'd7, 1'b0, 11, 32'd9, 32'd3, da, bn, dn, q, r, dz);
    checks++;
    if (dn !== 1) begin failures++; $display("FAIL busy_start_done_count got %0d required 1", dn); end
    checks++;
    if (q !== 32'd14 || r !== 32'd2) begin
      failures++;
      $display("FAIL busy_start_result q=%0d r=%0d required 14 2", q, r);
    end
  endtask

  task automatic test_reset_midrun();
    int da, bn, dn, nd;
    logic [W-1:0] q, r;
    logic dz;
    a = 32'd100;
    b = 32'd7;
    is_signed = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
      failures++;
      $display("FAIL midrun_reset busy=%b done=%b dz=%b q=%h r=%h required all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    nd = 0;
    for (int k = 0; k < W + 8; k++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    checks++;
    if (nd !== 0) begin failures++; $display("FAIL midrun_no_done got %0d required 0", nd); end
    run_div(32'd50, 32'd5, 1'b0, 0, '0, '0, da, bn, dn, q, r, dz);
    checks++;
    if (q !== 32'd10 || r !== 32'd0) begin
      failures++;
      $display("FAIL after_reset_div q=%0d r=%0d required 10 0", q, r);
    end
  endtask

`ifdef SIGNED_DIV_EN
  task automatic test_signed();
    int da, bn, dn;
    logic [W-1:0] q, r;
    logic dz;
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, '0, '0, da, bn, dn, q, r, dz);
    checks++;
    if (q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF || da !== W + 1) begin
      failures++;
      $display("FAIL signed_m7_by_2 q=%h r=%h lat=%0d required fffffffd ffffffff %0d", q, r, da, W + 1);
    end
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, '0, '0, da, bn, dn, q, r, dz);
    checks++;
    if (q !== 32'h8000_0000 || r !== 32'd0 || dz !== 1'b0) begin
      failures++;
      $display("FAIL signed_min_by_m1 q=%h r=%h dz=%b required 80000000 0 0", q, r, dz);
    end
    run_div(32'hFFFF_FFF0, 32'd0, 1'b1, 0, '0, '0, da, bn, dn, q, r, dz);
    checks++;
    if (q !== 32'hFFFF_FFFF || r !== 32'hFFFF_FFF0 || dz !== 1'b1) begin
      failures++;
      $display("FAIL signed_dz q=%h r=%h dz=%b required ffffffff fffffff0 1", q, r, dz);
    end
    test_random(1'b1, 12);
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    is_signed = 1'b0;
    test_reset();
    test_basic();
    test_div_zero();
    test_hold();
    test_edges();
    test_random(1'b0, 16);
    test_start_while_busy();
    test_reset_midrun();
`ifdef SIGNED_DIV_EN
    test_signed();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
